// File: rtl/cloud_gen.sv
//-----------------------------------------------------------------------------
// cloud_gen
//
// Produces the 16-bit cloud descriptor consumed by the cloud renderer:
//   cloud = {valid, y_offset[4:0], x_right[9:0]}
//
// One cloud is alive at a time. It spawns off the right edge of the screen,
// scrolls left by `speed` pixels on each frame step and retires once it would
// leave the left edge. A pseudo-random number of frames then passes before
// the next cloud spawns. A 16-bit Galois LFSR supplies the randomness.
//
// Optional feature (compile-time macro):
//   CLOUD_RAND_Y_EN  - when defined, the spawn y offset is lfsr[4:0];
//                      otherwise it is the fixed Y_OFFSET parameter.
//
// Ports:
//   clk         in   1   pixel clock
//   rst_n       in   1   asynchronous active-low reset
//   frame_tick  in   1   one-cycle pulse at vblank start
//   run         in   1   game running; low freezes all state
//   restart     in   1   synchronous pulse, returns the block to IDLE
//   speed       in   4   scroll distance in pixels per frame
//   cloud       out  16  registered descriptor
//-----------------------------------------------------------------------------
module cloud_gen #(
    parameter logic [9:0]  SPAWN_X   = 10'd732,
    parameter logic [7:0]  INIT_GAP  = 8'd8,
    parameter logic [7:0]  MIN_GAP   = 8'd30,
    parameter logic [4:0]  Y_OFFSET  = 5'd5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        restart,
    input  logic [3:0]  speed,
    output logic [15:0] cloud
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  gap;
    logic [7:0]  gap_next;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] cloud_next;

    logic        step;
    logic [15:0] lfsr_adv;
    logic [4:0]  spawn_y;
    logic        retire;

    assign step = frame_tick & run;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_adv = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);

`ifdef CLOUD_RAND_Y_EN
    assign spawn_y = lfsr[4:0];
`else
    assign spawn_y = Y_OFFSET;
`endif

    // Retiring when x <= speed means x = 0 is never shown and x never wraps.
    assign retire = (cloud[9:0] <= {6'b0, speed});

    // NOTE: every next-value is defaulted to "hold" before any branch, so no
    // path through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        gap_next   = gap;
        lfsr_next  = lfsr;
        cloud_next = cloud;

        if (restart) begin
            // Restart wins over a coincident tick; the LFSR keeps its value.
            state_next = S_IDLE;
            gap_next   = 8'd0;
            cloud_next = 16'h0000;
        end else if (run) begin
            // Sampled fields below read `lfsr`, i.e. the pre-advance value.
            if (step) begin
                lfsr_next = lfsr_adv;
            end

            case (state)
                S_IDLE: begin
                    cloud_next = 16'h0000;
                    gap_next   = INIT_GAP;
                    state_next = S_WAIT;
                end

                S_WAIT: begin
                    if (step) begin
                        if (gap == 8'd0) begin
                            cloud_next = {1'b1, spawn_y, SPAWN_X};
                            state_next = S_ACTIVE;
                        end else begin
                            gap_next = gap - 8'd1;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (step) begin
                        if (retire) begin
                            cloud_next = 16'h0000;
                            gap_next   = MIN_GAP + {2'b0, lfsr[5:0]};
                            state_next = S_WAIT;
                        end else begin
                            cloud_next[9:0] = cloud[9:0] - {6'b0, speed};
                        end
                    end
                end

                default: begin
                    cloud_next = 16'h0000;
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            gap   <= 8'd0;
            lfsr  <= LFSR_SEED;
            cloud <= 16'h0000;
        end else begin
            state <= state_next;
            gap   <= gap_next;
            lfsr  <= lfsr_next;
            cloud <= cloud_next;
        end
    end

endmodule

// File: tb/tb_cloud_gen.sv
//-----------------------------------------------------------------------------
// tb_cloud_gen
//
// Self-checking bench for cloud_gen. A behavioural model tracks the cloud's
// life cycle (idle / waiting / on screen) in plain integers and predicts the
// descriptor after every clock. Directed scenarios cover spawn timing, the
// retire boundary, speed 0, freeze, restart and asynchronous reset; a
// randomized phase follows. Build with +define+CLOUD_RAND_Y_EN to exercise
// the random-y variant.
//-----------------------------------------------------------------------------
module tb_cloud_gen;

    localparam int SPAWN_X  = 732;
    localparam int INIT_GAP = 8;
    localparam int MIN_GAP  = 30;
    localparam int Y_FIXED  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [15:0] cloud;

    cloud_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .run        (run),
        .restart    (restart),
        .speed      (speed),
        .cloud      (cloud)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_WAIT, M_ON} phase_t;

    phase_t      m_phase;
    int          m_gap;
    int          m_x;
    int          m_y;
    logic [15:0] m_lfsr;
    int          m_last_gap;

`ifdef CLOUD_RAND_Y_EN
    localparam bit RAND_Y = 1'b1;
`else
    localparam bit RAND_Y = 1'b0;
`endif

    // One step of division by x^16+x^14+x^13+x^11+1 (Galois form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [15:0] model_cloud();
        logic [4:0] y5;
        logic [9:0] x10;
        y5  = 5'(m_y);
        x10 = 10'(m_x);
        if (m_phase == M_ON) return {1'b1, y5, x10};
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_gap   = 0;
        m_x     = 0;
        m_y     = 0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_edge(input bit tk, input bit rn, input bit rs, input int sp);
        logic [15:0] pre;
        pre = m_lfsr;
        if (rs) begin
            m_phase = M_IDLE;
            m_gap   = 0;
            return;
        end
        if (!rn) return;
        if (tk) m_lfsr = lfsr_step(m_lfsr);
        case (m_phase)
            M_IDLE: begin
                m_gap   = INIT_GAP;
                m_phase = M_WAIT;
            end
            M_WAIT: if (tk) begin
                if (m_gap == 0) begin
                    m_phase = M_ON;
                    m_x     = SPAWN_X;
                    m_y     = RAND_Y ? int'(pre[4:0]) : Y_FIXED;
                end else begin
                    m_gap--;
                end
            end
            M_ON: if (tk) begin
                if (m_x <= sp) begin
                    m_phase    = M_WAIT;
                    m_gap      = MIN_GAP + int'(pre[5:0]);
                    m_last_gap = m_gap;
                end else begin
                    m_x = m_x - sp;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    // Called away from the clock edge; drives one cycle and checks the result.
    task automatic cyc(input bit tk, input bit rn, input bit rs, input int sp);
        frame_tick = tk;
        run        = rn;
        restart    = rs;
        speed      = 4'(sp);
        @(posedge clk);
        model_edge(tk, rn, rs, sp);
        #1;
        check("cycle", cloud, model_cloud());
    endtask

    task automatic tick(input int sp);
        cyc(1'b0, 1'b1, 1'b0, sp);
        cyc(1'b1, 1'b1, 1'b0, sp);
    endtask

    // Ticks until the DUT shows a valid cloud; returns the tick count.
    task automatic wait_spawn(output int n);
        n = 0;
        while (cloud[15] !== 1'b1 && n < 300) begin
            tick(3);
            n++;
        end
        if (cloud[15] !== 1'b1) check("spawn_timeout", 16'(cloud[15]), 16'h0001);
    endtask

    // Scrolls the live cloud down to x == target without retiring it.
    task automatic move_to(input int target);
        int guard;
        guard = 0;
        while (m_phase == M_ON && m_x > target && guard < 300) begin
            tick((m_x - target > 15) ? 15 : (m_x - target));
            guard++;
        end
        check("move_to", 16'(cloud[9:0]), 16'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [15:0] saved;
        logic [15:0] exp16;
        int          n;

        model_reset();
        m_last_gap = 0;
        #12;
        check("reset", cloud, 16'h0000);
        rst_n = 1'b1;
        #6;

        // First spawn: IDLE -> WAIT needs no tick, then INIT_GAP+1 ticks.
        cyc(1'b0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("pre_spawn", cloud, 16'h0000);
            tick(2);
        end
        v = 16'hACE1;
        for (int i = 0; i < 8; i++) v = lfsr_step(v);
        exp16 = RAND_Y ? {1'b1, v[4:0], 10'd732} : 16'h96DC;
        check("spawn_9", cloud, exp16);
        tick(2);
        exp16 = RAND_Y ? {1'b1, v[4:0], 10'd730} : 16'h96DA;
        check("tick_10", cloud, exp16);

        // speed 0 never moves the cloud.
        saved = cloud;
        for (int i = 0; i < 5; i++) tick(0);
        check("speed0", cloud, saved);

        // x = 5, speed 4 -> x = 1; then 1 <= 4 retires.
        move_to(5);
        tick(4);
        check("x5_to_1", cloud, {saved[15:10], 10'd1});
        tick(4);
        check("x1_retire", cloud, 16'h0000);
        wait_spawn(n);
        check("gap_range", 16'((n - 1 >= 30) && (n - 1 <= 93)), 16'h0001);
        check("gap_model", 16'(n - 1), 16'(m_last_gap));

        // x == speed exactly retires.
        move_to(4);
        tick(4);
        check("x_eq_speed", cloud, 16'h0000);
        wait_spawn(n);
        check("gap_model2", 16'(n - 1), 16'(m_last_gap));

        // Freeze at x = 500 for 20 ticks.
        move_to(500);
        saved = cloud;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0, $urandom_range(1, 15));
            cyc(1'b1, 1'b0, 1'b0, $urandom_range(1, 15));
        end
        check("freeze", cloud, saved);
        move_to(1);
        tick(15);
        wait_spawn(n);
        check("gap_after_freeze", 16'(n - 1), 16'(m_last_gap));
        check("y_after_freeze", 16'(cloud[14:10]), 16'(m_y));

        // restart coincident with a tick while on screen.
        tick(3);
        cyc(1'b1, 1'b1, 1'b1, 3);
        check("restart", cloud, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 3);
        wait_spawn(n);
        check("restart_spawn", 16'(n), 16'(INIT_GAP + 1));

        // Asynchronous reset mid-flight clears the descriptor at once.
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", cloud, 16'h0000);
        model_reset();
        @(posedge clk);
        #3;
        check("reset_hold", cloud, 16'h0000);
        rst_n = 1'b1;
        #3;

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 299) == 0), $urandom_range(0, 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
